// File: rtl/bitserial_alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// bitserial_alu_arbiter_if
// Client-side bus of the two-port bit-serial ALU arbiter.
//   req_valid[1:0]  per-port request valid (bit i = port i)
//   req_ready[1:0]  per-port request accept, at most one bit set
//   req_op[7:0]     {port1 op, port0 op}
//   req_a/req_b     {port1, port0} 32-bit operands
//   rsp_valid[1:0]  per-port response valid
//   rsp_ready[1:0]  per-port response accept
//   rsp_result      result for the port whose rsp_valid bit is set
//   rsp_err         watchdog timeout flag
// Modports: master = request clients, slave = arbiter.
// -----------------------------------------------------------------------------
interface bitserial_alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/bitserial_alu_arbiter.sv
// -----------------------------------------------------------------------------
// bitserial_alu_arbiter
// Arbitrates two request ports onto one bit-serial ALU. A granted request is
// issued to the ALU with a single alu_start pulse, the arbiter waits for
// alu_done, then presents the result to the granting port until accepted.
// Ties between ports alternate, starting with port 0 after reset.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bus (slave)         request/response bus, see bitserial_alu_arbiter_if
//   alu_start           one-cycle issue pulse to the ALU
//   alu_op/alu_a/alu_b  operation and operands driven to the ALU
//   alu_result/alu_done ALU completion pulse and its result
//   busy                high whenever a transaction is in flight
//   grant_id            port currently being served
//
// Parameter TIMEOUT_CYCLES: WAIT-state watchdog limit in clk cycles.
// Optional feature macro BITSERIAL_ALU_ARB_TIMEOUT_EN: when defined, a WAIT
// lasting TIMEOUT_CYCLES without alu_done ends with rsp_result=0, rsp_err=1.
// When undefined, WAIT lasts until alu_done and rsp_err is always 0.
// -----------------------------------------------------------------------------
module bitserial_alu_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  bitserial_alu_arbiter_if.slave bus,
  output logic                   alu_start,
  output logic [3:0]             alu_op,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  input  logic [31:0]            alu_result,
  input  logic                   alu_done,
  output logic                   busy,
  output logic                   grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [1:0]  grant_s;
  logic        hs_s;
  logic        hs_port_s;
  logic        timeout_s;
  logic        last_served_r;
  logic        grant_id_r;
  logic [3:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] rsp_result_r;
  logic        rsp_err_r;
  logic [1:0]  rsp_valid_r;
  logic        alu_start_r;
  logic        busy_r;

  // Grant selection in IDLE: a lone valid port wins, a tie goes to the port
  // not served last. Gated by rst so req_ready drops the moment reset rises.
  always_comb begin
    grant_s = 2'b00;
    if ((state_r == ST_IDLE) && !rst) begin
      case (bus.req_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = last_served_r ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  // grant_s is only non-zero for a valid port, so any grant is a handshake.
  assign hs_s      = |grant_s;
  assign hs_port_s = grant_s[1];

`ifdef BITSERIAL_ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_r;

  // WAIT-cycle counter; held at zero outside WAIT so every entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_WAIT) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end
  end

  // The cycle holding count TIMEOUT_CYCLES-1 is the last WAIT cycle allowed.
  assign timeout_s = (state_r == ST_WAIT) &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; alu_done is only looked at in WAIT.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_done) begin
          next_state_s = ST_RESP;
        end else if (timeout_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready[grant_id_r]) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. Strobes are decoded from next_state_s so
  // they are aligned with the state they belong to; captured operands stay put
  // until the next handshake, and the result only changes on WAIT exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_served_r <= 1'b1;
      grant_id_r    <= 1'b0;
      op_r          <= 4'd0;
      a_r           <= 32'd0;
      b_r           <= 32'd0;
      rsp_result_r  <= 32'd0;
      rsp_err_r     <= 1'b0;
      rsp_valid_r   <= 2'b00;
      alu_start_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      alu_start_r <= (next_state_s == ST_ISSUE);
      busy_r      <= (next_state_s != ST_IDLE);
      if ((state_r == ST_IDLE) && hs_s) begin
        grant_id_r    <= hs_port_s;
        last_served_r <= hs_port_s;
        op_r          <= hs_port_s ? bus.req_op[7:4]  : bus.req_op[3:0];
        a_r           <= hs_port_s ? bus.req_a[63:32] : bus.req_a[31:0];
        b_r           <= hs_port_s ? bus.req_b[63:32] : bus.req_b[31:0];
      end
      if (state_r == ST_WAIT) begin
        if (alu_done) begin
          rsp_result_r <= alu_result;
          rsp_err_r    <= 1'b0;
        end else if (timeout_s) begin
          rsp_result_r <= 32'd0;
          rsp_err_r    <= 1'b1;
        end
      end
      // grant_id_r is fixed long before RESP is entered.
      if (next_state_s == ST_RESP) begin
        rsp_valid_r <= grant_id_r ? 2'b10 : 2'b01;
      end else begin
        rsp_valid_r <= 2'b00;
      end
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_err    = rsp_err_r;
  assign alu_start      = alu_start_r;
  assign alu_op         = op_r;
  assign alu_a          = a_r;
  assign alu_b          = b_r;
  assign busy           = busy_r;
  assign grant_id       = grant_id_r;

endmodule

// File: tb/tb_bitserial_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bitserial_alu_arbiter
// Self-checking bench: a transaction-level reference model is stepped once per
// cycle (sampled on the falling edge) and compared against every DUT output.
// A behavioural bit-serial ALU responds to alu_start after a programmable
// latency and injects stray alu_done pulses while no operation is outstanding.
// Directed scenarios pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_bitserial_alu_arbiter;
  localparam int TO = 64;

  logic        clk;
  logic        rst;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_done;
  logic        busy;
  logic        grant_id;

  bitserial_alu_arbiter_if bus ();

  bitserial_alu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_done   (alu_done),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase of the current transaction (0 none, 1 issue cycle,
  // 2 waiting on the ALU, 3 response presented) plus the captured request.
  int          m_ph;
  logic        m_last;
  logic        m_gid;
  logic [3:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [31:0] m_res;
  logic        m_err;
  int          m_wcnt;
  bit          hs_seen;
  logic        hs_port;
  int          n_starts;
  int          grant_log[$];

  // Behavioural ALU state: -1 idle, -2 muted (never answers), >=0 countdown.
  int          alu_cnt = -1;
  logic [31:0] alu_pend;
  int          lat_min = 1;
  int          lat_max = 40;
  bit          mute = 1'b0;
  bit          spurious = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      default: return a ^ b ^ {28'h5A5A5A5, op};
    endcase
  endfunction

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic reset_out_chk(input string nm);
    chk({nm, "_req_ready"}, bus.req_ready, 32'd0);
    chk({nm, "_rsp_valid"}, bus.rsp_valid, 32'd0);
    chk({nm, "_rsp_result"}, bus.rsp_result, 32'd0);
    chk({nm, "_rsp_err"}, bus.rsp_err, 32'd0);
    chk({nm, "_alu_start"}, alu_start, 32'd0);
    chk({nm, "_alu_op"}, alu_op, 32'd0);
    chk({nm, "_alu_a"}, alu_a, 32'd0);
    chk({nm, "_alu_b"}, alu_b, 32'd0);
    chk({nm, "_busy"}, busy, 32'd0);
    chk({nm, "_grant_id"}, grant_id, 32'd0);
  endtask

  // One model step: compare outputs for the current cycle, then advance the
  // model by what happens at the coming rising edge.
  task automatic model_step();
    logic [1:0] g;
    logic       p;
    hs_seen = 1'b0;
    if (rst) begin
      reset_out_chk("reset");
      m_ph = 0; m_last = 1'b1; m_gid = 1'b0;
      return;
    end
    g = (m_ph == 0) ? exp_grant(bus.req_valid, m_last) : 2'b00;
    chk("req_ready", bus.req_ready, g);
    chk("busy", busy, (m_ph != 0));
    chk("grant_id", grant_id, m_gid);
    chk("alu_start", alu_start, (m_ph == 1));
    chk("rsp_valid", bus.rsp_valid, (m_ph == 3) ? (m_gid ? 2'b10 : 2'b01) : 2'b00);
    if (m_ph == 1 || m_ph == 2) begin
      chk("alu_op", alu_op, m_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
    end
    if (m_ph == 3) begin
      chk("rsp_result", bus.rsp_result, m_res);
      chk("rsp_err", bus.rsp_err, m_err);
    end
    case (m_ph)
      0: if (g != 2'b00) begin
        p = g[1];
        m_op = p ? bus.req_op[7:4] : bus.req_op[3:0];
        m_a  = p ? bus.req_a[63:32] : bus.req_a[31:0];
        m_b  = p ? bus.req_b[63:32] : bus.req_b[31:0];
        m_last = p; m_gid = p;
        hs_seen = 1'b1; hs_port = p;
        grant_log.push_back(int'(p));
        m_ph = 1;
      end
      1: begin n_starts++; m_wcnt = 0; m_ph = 2; end
      2: begin
        if (alu_done) begin
          m_res = alu_result; m_err = 1'b0; m_ph = 3;
        end else begin
          m_wcnt++;
`ifdef BITSERIAL_ALU_ARB_TIMEOUT_EN
          if (m_wcnt == TO) begin m_res = 32'd0; m_err = 1'b1; m_ph = 3; end
`endif
        end
      end
      3: if (bus.rsp_ready[m_gid]) m_ph = 0;
      default: m_ph = 0;
    endcase
  endtask

  // Behavioural ALU, driven just after each rising edge.
  task automatic bfm_step();
    if (rst) begin
      alu_cnt = -1; alu_done = 1'b0;
      return;
    end
    if (alu_cnt == 0) begin
      alu_done = 1'b1; alu_result = alu_pend; alu_cnt = -1;
    end else begin
      alu_done = 1'b0;
      if (alu_cnt > 0) alu_cnt--;
      else if (alu_cnt == -1 && spurious && $urandom_range(0, 15) == 0) begin
        alu_done = 1'b1; alu_result = $urandom;
      end
    end
    if (alu_start) begin
      alu_pend = alu_fn(alu_op, alu_a, alu_b);
      alu_cnt  = mute ? -2 : int'($urandom_range(lat_min, lat_max)) - 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    bfm_step();
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_valid[p]      = 1'b1;
    bus.req_op[p*4 +: 4]  = op;
    bus.req_a[p*32 +: 32] = a;
    bus.req_b[p*32 +: 32] = b;
  endtask

  task automatic rand_req(input int p);
    logic [31:0] b;
    b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
    set_req(p, 4'($urandom_range(0, 15)), $urandom, b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (alu_start) return;
    end
    chk({nm, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input string nm, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (bus.rsp_valid != 2'b00) return;
    end
    chk({nm, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain(input string nm);
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 300; i++) begin
      tick();
      bus.req_valid = 2'b00;
      if (m_ph == 0) return;
    end
    chk({nm, "_drain_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int stable;
    rst = 1'b0;
    bus.req_valid = 2'b00; bus.req_op = 8'd0; bus.req_a = 64'd0; bus.req_b = 64'd0;
    bus.rsp_ready = 2'b00;
    alu_done = 1'b0; alu_result = 32'd0;
    m_ph = 0; m_last = 1'b1; m_gid = 1'b0; n_starts = 0;
    m_op = 4'd0; m_a = 32'd0; m_b = 32'd0; m_res = 32'd0; m_err = 1'b0; m_wcnt = 0;
    #1;
    do_reset();

    // Port 0 ADD 5+7 with a 33-cycle ALU.
    spurious = 1'b0; lat_min = 33; lat_max = 33;
    set_req(0, 4'd0, 32'd5, 32'd7);
    wait_start("add");
    chk("add_alu_op", alu_op, 32'd0);
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    bus.req_valid = 2'b00;
    wait_rsp("add", n);
    chk("add_latency", n, 32'd34);
    chk("add_rsp_valid", bus.rsp_valid, 32'h1);
    chk("add_rsp_result", bus.rsp_result, 32'd12);
    chk("add_rsp_err", bus.rsp_err, 32'd0);
    drain("add");

    // Port 1 SUB 3-5; response held 10 cycles with only port 0's ready high.
    lat_min = 5; lat_max = 10; spurious = 1'b1;
    bus.rsp_ready = 2'b01;
    set_req(1, 4'd1, 32'd3, 32'd5);
    wait_start("sub");
    bus.req_valid[1] = 1'b0;
    set_req(0, 4'd4, $urandom, $urandom);
    wait_rsp("sub", n);
    chk("sub_rsp_valid", bus.rsp_valid, 32'h2);
    chk("sub_rsp_result", bus.rsp_result, 32'hFFFFFFFE);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid == 2'b10 && bus.rsp_result == 32'hFFFFFFFE &&
          bus.req_ready == 2'b00 && !alu_start) stable++;
    end
    chk("hold_stable_cycles", stable, 32'd10);
    bus.rsp_ready = 2'b10;
    tick();
    chk("after_rsp_req_ready", bus.req_ready, 32'h1);
    drain("hold");

    // Fairness from reset: both ports continuously valid for 8 grants.
    do_reset();
    lat_min = 1; lat_max = 6;
    grant_log.delete();
    n_starts = 0;
    rand_req(0); rand_req(1);
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 600 && grant_log.size() < 8; i++) begin
      tick();
      if (hs_seen) rand_req(int'(hs_port));
    end
    bus.req_valid = 2'b00;
    drain("fair");
    chk("fair_grant_count", grant_log.size(), 32'd8);
    if (grant_log.size() == 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("fair_grant_%0d", i), grant_log[i], i % 2);
    end
    chk("fair_starts", n_starts, 32'd8);

    // Reset pulsed mid-WAIT, then a late alu_done after release.
    lat_min = 20; lat_max = 20; spurious = 1'b0;
    set_req(0, 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    wait_start("rstwait");
    repeat (3) tick();
    rst = 1'b1;
    #1;
    reset_out_chk("rst_now");
    repeat (2) tick();
    rst = 1'b0;
    bus.req_valid = 2'b00;
    tick();
    alu_done = 1'b1; alu_result = 32'h1234_5678;
    tick();
    tick();
    chk("late_done_rsp_valid", bus.rsp_valid, 32'd0);
    chk("late_done_busy", busy, 32'd0);

    // ALU that never answers.
    mute = 1'b1;
    set_req(0, 4'd3, 32'd1, 32'd2);
    wait_start("mute");
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
`ifdef BITSERIAL_ALU_ARB_TIMEOUT_EN
    wait_rsp("timeout", n);
    chk("timeout_latency", n, 32'd65);
    chk("timeout_rsp_valid", bus.rsp_valid, 32'h1);
    chk("timeout_rsp_result", bus.rsp_result, 32'd0);
    chk("timeout_rsp_err", bus.rsp_err, 32'd1);
    drain("timeout");
    mute = 1'b0;
`else
    repeat (100) tick();
    chk("no_timeout_busy", busy, 32'd1);
    chk("no_timeout_rsp_valid", bus.rsp_valid, 32'd0);
    mute = 1'b0;
    do_reset();
`endif

    // Randomized traffic.
    spurious = 1'b1; lat_min = 1; lat_max = 40;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (bus.req_valid[p]) begin
          if (hs_seen && int'(hs_port) == p) begin
            if ($urandom_range(0, 1) == 1) rand_req(p);
            else bus.req_valid[p] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          rand_req(p);
        end
      end
      bus.rsp_ready = 2'($urandom_range(0, 3));
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitserial_alu_arbiter.md
BITSERIAL_ALU_ARBITER -- requirements
Module: bitserial_alu_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, sets the WAIT-state watchdog limit in clk cycles (used only under REQ-026).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-port request valid, bit i = port i.
REQ-005 req_ready  output  2  per-port request accept, at most one bit set.
REQ-006 req_op  input  8  {port1 op[3:0], port0 op[3:0]}, ALU op encoding 0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR, 5=SLL, 6=SRL, 7=SRA.
REQ-007 req_a / req_b  input  64 each  {port1, port0} 32-bit operands.
REQ-008 rsp_valid  output  2  per-port response valid.
REQ-009 rsp_ready  input  2  per-port response accept.
REQ-010 rsp_result  output  32  result for the port whose rsp_valid bit is set; rsp_err  output  1  timeout flag.
REQ-011 alu_start  output  1 / alu_op  output  4 / alu_a, alu_b  output  32 each: drive the bit-serial ALU.
REQ-012 alu_result  input  32 / alu_done  input  1: ALU completion pulse and its result.
REQ-013 busy  output  1  high in any state other than IDLE; grant_id  output  1  port currently served.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, RESP; transitions occur only as stated in REQ-015 to REQ-021.
REQ-015 IDLE: req_ready is combinational, one-hot. Single valid port is granted. Both valid: grant the port != last_served.
REQ-016 Handshake (req_valid[i] & req_ready[i]): capture op/a/b of port i, set grant_id and last_served to i, go to ISSUE; no handshake keeps IDLE.
REQ-017 ISSUE: alu_start=1 for exactly one cycle with captured op/a/b, go to WAIT; alu_op/alu_a/alu_b stay stable from ISSUE until the WAIT exit.
REQ-018 WAIT: alu_done=1 captures alu_result into rsp_result, clears rsp_err, and goes to RESP. alu_done is ignored in every other state.
REQ-019 RESP: rsp_valid[grant_id]=1, rsp_result/rsp_err held stable; on rsp_ready[grant_id] go to IDLE; rsp_ready of the other port is ignored.
REQ-020 Latency: alu_start in cycle T+1 after handshake in cycle T; rsp_valid asserts in the cycle after alu_done is sampled. The next handshake occurs no earlier than the cycle after the response handshake.
REQ-021 req_ready=0 and alu_start=0 outside IDLE/ISSUE respectively; a non-granted valid port stays pending with no side effects.
REQ-022 Fairness: with both ports continuously valid, grants strictly alternate.
REQ-023 Op values 8-15 are forwarded unchanged; the response is whatever the ALU returns.

Reset
REQ-024 rst=1 immediately forces: state IDLE, req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, alu_start=0, alu_op/alu_a/alu_b=0, busy=0, grant_id=0, last_served=1 (port 0 wins first tie).
REQ-025 Reset mid-operation abandons the transaction with no response. An alu_done arriving after reset release is ignored in IDLE.

Configuration
REQ-026 Macro BITSERIAL_ALU_ARB_TIMEOUT_EN defined: a counter clears on WAIT entry and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without alu_done, go to RESP with rsp_result=0 and rsp_err=1. Macro undefined: no counter, rsp_err tied 0, WAIT lasts until alu_done.

Verification
REQ-027 Port0 ADD a=5 b=7: one alu_start pulse with alu_op=0, alu_a=5, alu_b=7; ALU model pulses done with 12 after 33 cycles -> rsp_valid=2'b01, rsp_result=12, rsp_err=0.
REQ-028 From reset, both ports continuously valid for 4 requests each -> grant_id sequence 0,1,0,1,0,1,0,1, one alu_start per grant.
REQ-029 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/rsp_result stable, req_ready=0, no alu_start; rsp_ready[other port]=1 has no effect.
REQ-030 rst pulsed during WAIT -> all outputs 0 immediately; alu_done=1 one cycle after release -> no rsp_valid, busy=0.
REQ-031 Macro defined, TIMEOUT_CYCLES=64, alu_done never asserted -> rsp_valid after 64 WAIT cycles with rsp_result=0, rsp_err=1. Macro undefined -> busy stays 1 indefinitely.
REQ-032 With a real bitserial ALU instance, port1 SUB a=3 b=5 -> rsp_valid=2'b10, rsp_result=0xFFFFFFFE.
